game_flow_controller: RTL and testbench

Frame-rate game sequencer sitting between the sync generator, collision detector and the entity logic (player, dragon, sheep).
- Owns the TITLE/PLAY/HURT/OVER state machine and the life count.
- Grants per-frame update enables and issues entity reset pulses.
- Provides hurt-blink visibility for the PPU player entity.
- Replaces the ad-hoc hurt/reset wiring currently spread across the top level.

---
 rtl/game_pkg.sv | 22 ++
 rtl/frame_countdown.sv | 27 ++
 rtl/game_flow_controller.sv | 164 ++++++++++++++++
 tb/tb_game_flow_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and widths for the game flow sequencer and its helpers.
package game_pkg;

    localparam int unsigned STATE_W   = 2;
    localparam int unsigned MAX_LIVES = 3;
    localparam int unsigned LIVES_W   = $clog2(MAX_LIVES + 1);
    localparam int unsigned FRAME_W   = 8;
    localparam int unsigned HITS_W    = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_TITLE = 2'b00,
        ST_PLAY  = 2'b01,
        ST_HURT  = 2'b10,
        ST_OVER  = 2'b11
    } state_e;

    // Increment that sticks at all-ones.
    function automatic logic [HITS_W-1:0] sat_inc(input logic [HITS_W-1:0] v);
        return (v == '1) ? v : v + HITS_W'(1);
    endfunction

endpackage

// File: rtl/frame_countdown.sv
// Loadable frame down-counter that decrements on tick and holds at zero.
module frame_countdown
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_val,
    output logic               zero_c
);

    logic [FRAME_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - FRAME_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/game_flow_controller.sv
// Frame-rate TITLE/PLAY/HURT/OVER sequencer: lives, update grants, entity
// reset pulses, hurt blink and sword hit tally.
module game_flow_controller
    import game_pkg::*;
#(
    parameter int unsigned START_LIVES = 3,
    parameter int unsigned HURT_FRAMES = 60,
    parameter int unsigned OVER_FRAMES = 120,
    parameter int unsigned BLINK_LOG2  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_end,
    input  logic               start_btn,
    input  logic               player_dragon_collision,
    input  logic               sword_dragon_collision,
    output logic [STATE_W-1:0] game_state,
    output logic [LIVES_W-1:0] lives,
    output logic               update_en,
    output logic               game_reset,
    output logic               player_reset,
    output logic               invuln,
    output logic               player_visible,
    output logic [HITS_W-1:0]  hit_count
);

    state_e                state, state_nx;
    logic                  pd_lat, sw_lat, start_prev;
    logic                  pd_hit_c, sw_hit_c, start_rise_c, cnt_zero_c;
    logic [BLINK_LOG2-1:0] blink_cnt, blink_nx;
    logic [LIVES_W-1:0]    lives_nx;
    logic [HITS_W-1:0]     hit_nx;
    logic                  update_nx, game_reset_nx, player_reset_nx;
    logic                  invuln_nx, visible_nx, cnt_load;
    logic [FRAME_W-1:0]    cnt_val;

    // A collision anywhere in the frame, including on the tick itself, counts.
    assign pd_hit_c     = pd_lat | player_dragon_collision;
    assign sw_hit_c     = sw_lat | sword_dragon_collision;
    assign start_rise_c = start_btn & ~start_prev;

    frame_countdown u_countdown (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (frame_end),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero_c   (cnt_zero_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_TITLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (frame_end) begin
            case (state)
                ST_TITLE: if (start_rise_c) state_nx = ST_PLAY;
                ST_PLAY:  if (pd_hit_c) state_nx = (lives > LIVES_W'(1)) ? ST_HURT : ST_OVER;
                ST_HURT:  if (cnt_zero_c) state_nx = ST_PLAY;
                ST_OVER:  if (cnt_zero_c && start_rise_c) state_nx = ST_TITLE;
                default:  state_nx = ST_TITLE;
            endcase
        end
    end

    always_comb begin
        lives_nx        = lives;
        hit_nx          = hit_count;
        update_nx       = 1'b0;
        game_reset_nx   = 1'b0;
        player_reset_nx = 1'b0;
        invuln_nx       = invuln;
        visible_nx      = player_visible;
        blink_nx        = blink_cnt;
        cnt_load        = 1'b0;
        cnt_val         = '0;
        if (frame_end) begin
            case (state)
                ST_TITLE: begin
                    if (start_rise_c) begin
                        lives_nx      = LIVES_W'(START_LIVES);
                        hit_nx        = '0;
                        game_reset_nx = 1'b1;
                    end
                end
                ST_PLAY: begin
                    update_nx = 1'b1;
                    if (sw_hit_c) hit_nx = sat_inc(hit_count);
                    if (pd_hit_c) begin
                        cnt_load = 1'b1;
                        if (lives > LIVES_W'(1)) begin
                            lives_nx        = lives - LIVES_W'(1);
                            cnt_val         = FRAME_W'(HURT_FRAMES - 1);
                            blink_nx        = '0;
                            player_reset_nx = 1'b1;
                            invuln_nx       = 1'b1;
                        end else begin
                            lives_nx   = '0;
                            cnt_val    = FRAME_W'(OVER_FRAMES - 1);
                            visible_nx = 1'b0;
                        end
                    end
                end
                ST_HURT: begin
                    update_nx = 1'b1;
                    if (sw_hit_c) hit_nx = sat_inc(hit_count);
                    blink_nx = blink_cnt + BLINK_LOG2'(1);
                    if (cnt_zero_c) begin
                        visible_nx = 1'b1;
                        invuln_nx  = 1'b0;
                    end else if (blink_cnt == '1) begin
                        visible_nx = ~player_visible;
                    end
                end
                ST_OVER: begin
                    visible_nx = 1'b0;
                    if (cnt_zero_c && start_rise_c) begin
                        lives_nx   = LIVES_W'(START_LIVES);
                        visible_nx = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky collision flags, start edge history and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pd_lat         <= 1'b0;
            sw_lat         <= 1'b0;
            start_prev     <= 1'b0;
            blink_cnt      <= '0;
            lives          <= LIVES_W'(START_LIVES);
            hit_count      <= '0;
            update_en      <= 1'b0;
            game_reset     <= 1'b0;
            player_reset   <= 1'b0;
            invuln         <= 1'b0;
            player_visible <= 1'b1;
        end else begin
            pd_lat         <= frame_end ? 1'b0 : (pd_lat | player_dragon_collision);
            sw_lat         <= frame_end ? 1'b0 : (sw_lat | sword_dragon_collision);
            start_prev     <= frame_end ? start_btn : start_prev;
            blink_cnt      <= blink_nx;
            lives          <= lives_nx;
            hit_count      <= hit_nx;
            update_en      <= update_nx;
            game_reset     <= game_reset_nx;
            player_reset   <= player_reset_nx;
            invuln         <= invuln_nx;
            player_visible <= visible_nx;
        end
    end

    assign game_state = state;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with a frame-level reference model.
module tb_game_flow_controller;

    localparam int unsigned START_LIVES = 3;
    localparam int unsigned HURT_FRAMES = 4;
    localparam int unsigned OVER_FRAMES = 5;
    localparam int unsigned BLINK_LOG2  = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_end = 1'b0;
    logic       start_btn = 1'b0;
    logic       pd = 1'b0;
    logic       sw = 1'b0;
    logic [1:0] game_state;
    logic [1:0] lives;
    logic       update_en, game_reset, player_reset, invuln, player_visible;
    logic [3:0] hit_count;

    int n_checks = 0;
    int n_pass   = 0;

    game_flow_controller #(
        .START_LIVES (START_LIVES),
        .HURT_FRAMES (HURT_FRAMES),
        .OVER_FRAMES (OVER_FRAMES),
        .BLINK_LOG2  (BLINK_LOG2)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .frame_end               (frame_end),
        .start_btn               (start_btn),
        .player_dragon_collision (pd),
        .sword_dragon_collision  (sw),
        .game_state              (game_state),
        .lives                   (lives),
        .update_en               (update_en),
        .game_reset              (game_reset),
        .player_reset            (player_reset),
        .invuln                  (invuln),
        .player_visible          (player_visible),
        .hit_count               (hit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: phase names and frames-elapsed counters, per frame.
    int m_state = 0, m_lives = START_LIVES, m_hits = 0;
    int m_upd = 0, m_grst = 0, m_prst = 0, m_inv = 0, m_vis = 1;
    int m_hurt_ticks = 0, m_over_ticks = 0;
    bit pd_seen = 0, sw_seen = 0, prev_start = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_lives = START_LIVES; m_hits = 0;
            m_upd = 0; m_grst = 0; m_prst = 0; m_inv = 0; m_vis = 1;
            m_hurt_ticks = 0; m_over_ticks = 0;
            pd_seen = 0; sw_seen = 0; prev_start = 0;
        end else begin
            bit p, s, rise;
            m_upd = 0; m_grst = 0; m_prst = 0;
            if (frame_end) begin
                p = pd_seen | pd;
                s = sw_seen | sw;
                rise = start_btn && !prev_start;
                prev_start = start_btn;
                pd_seen = 0; sw_seen = 0;
                case (m_state)
                    0: if (rise) begin
                        m_state = 1; m_lives = START_LIVES; m_hits = 0; m_grst = 1;
                    end
                    1: begin
                        m_upd = 1;
                        if (s) m_hits = (m_hits + 1 > 15) ? 15 : m_hits + 1;
                        if (p) begin
                            if (m_lives > 1) begin
                                m_lives--; m_state = 2; m_prst = 1; m_inv = 1; m_hurt_ticks = 0;
                            end else begin
                                m_lives = 0; m_state = 3; m_vis = 0; m_over_ticks = 0;
                            end
                        end
                    end
                    2: begin
                        m_upd = 1;
                        if (s) m_hits = (m_hits + 1 > 15) ? 15 : m_hits + 1;
                        m_hurt_ticks++;
                        if (m_hurt_ticks == HURT_FRAMES) begin
                            m_state = 1; m_vis = 1; m_inv = 0;
                        end else if (m_hurt_ticks % (1 << BLINK_LOG2) == 0) begin
                            m_vis = 1 - m_vis;
                        end
                    end
                    default: begin
                        m_over_ticks++;
                        m_vis = 0;
                        if (rise && m_over_ticks >= OVER_FRAMES) begin
                            m_state = 0; m_lives = START_LIVES; m_vis = 1;
                        end
                    end
                endcase
            end else begin
                pd_seen = pd_seen | pd;
                sw_seen = sw_seen | sw;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("m_game_state", 32'(game_state), 32'(m_state));
            check("m_lives", 32'(lives), 32'(m_lives));
            check("m_update_en", 32'(update_en), 32'(m_upd));
            check("m_game_reset", 32'(game_reset), 32'(m_grst));
            check("m_player_reset", 32'(player_reset), 32'(m_prst));
            check("m_invuln", 32'(invuln), 32'(m_inv));
            check("m_player_visible", 32'(player_visible), 32'(m_vis));
            check("m_hit_count", 32'(hit_count), 32'(m_hits));
        end
    end

    task automatic step(input logic fe);
        frame_end = fe;
        @(posedge clk);
        #1;
        frame_end = 1'b0;
    endtask

    task automatic frame();
        repeat (3) step(1'b0);
        step(1'b1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_state", 32'(game_state), 0);
        check("rst_lives", 32'(lives), 3);
        check("rst_visible", 32'(player_visible), 1);

        // Start held across three ticks: one game_reset only.
        start_btn = 1'b1;
        frame();
        check("start_game_reset", 32'(game_reset), 1);
        check("start_state", 32'(game_state), 1);
        check("start_lives", 32'(lives), 3);
        frame();
        check("held_no_reset", 32'(game_reset), 0);
        check("play_update", 32'(update_en), 1);
        frame();
        start_btn = 1'b0;

        // One-cycle player collision mid-frame.
        step(1'b0); pd = 1'b1; step(1'b0); pd = 1'b0; step(1'b0); step(1'b1);
        check("hit_lives", 32'(lives), 2);
        check("hit_state", 32'(game_state), 2);
        check("hit_player_reset", 32'(player_reset), 1);
        check("hit_invuln", 32'(invuln), 1);

        // Collisions held during HURT; blink every two frames.
        pd = 1'b1; sw = 1'b1;
        frame();
        check("blink_f1", 32'(player_visible), 1);
        frame();
        check("blink_f2", 32'(player_visible), 0);
        frame();
        check("blink_f3", 32'(player_visible), 0);
        frame();
        check("hurt_exit_state", 32'(game_state), 1);
        check("hurt_exit_visible", 32'(player_visible), 1);
        check("hurt_exit_invuln", 32'(invuln), 0);
        check("hurt_lives_kept", 32'(lives), 2);
        check("hurt_hits", 32'(hit_count), 4);
        frame();
        check("replay_hit_lives", 32'(lives), 1);
        check("replay_hit_state", 32'(game_state), 2);
        pd = 1'b0;
        repeat (15) frame();
        check("hits_saturated", 32'(hit_count), 15);
        sw = 1'b0;

        // Last life lost by a collision coincident with the tick.
        repeat (3) step(1'b0);
        pd = 1'b1; step(1'b1); pd = 1'b0;
        check("over_lives", 32'(lives), 0);
        check("over_state", 32'(game_state), 3);
        check("over_no_player_reset", 32'(player_reset), 0);
        start_btn = 1'b1;
        frame();
        check("over_update_silent", 32'(update_en), 0);
        check("over_invisible", 32'(player_visible), 0);
        check("early_start_ignored", 32'(game_state), 3);
        repeat (4) frame();
        check("held_start_ignored", 32'(game_state), 3);
        start_btn = 1'b0;
        frame();
        start_btn = 1'b1;
        frame();
        check("restart_state", 32'(game_state), 0);
        check("restart_lives", 32'(lives), 3);

        // New game, then asynchronous reset in the middle of HURT.
        start_btn = 1'b0; frame();
        start_btn = 1'b1; frame();
        check("new_game_state", 32'(game_state), 1);
        check("new_game_hits", 32'(hit_count), 0);
        start_btn = 1'b0;
        repeat (3) step(1'b0);
        pd = 1'b1; step(1'b1); pd = 1'b0;
        frame();
        check("pre_reset_state", 32'(game_state), 2);
        step(1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_state", 32'(game_state), 0);
        check("async_lives", 32'(lives), 3);
        check("async_invuln", 32'(invuln), 0);
        check("async_visible", 32'(player_visible), 1);
        check("async_update", 32'(update_en), 0);
        check("async_player_reset", 32'(player_reset), 0);
        check("async_hits", 32'(hit_count), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        frame();
        check("post_reset_no_pulse", 32'(game_reset), 0);
        start_btn = 1'b1; frame();
        check("post_reset_start", 32'(game_state), 1);
        start_btn = 1'b0;
        frame();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
